blob_frame_ctrl: RTL and testbench

- Frame-level sequencer for the binary blob counter: clears it, streams exactly one frame of binarized camera pixels into it, and collects and holds the count.
- Sits between the thresholding stage (pixel stream plus start-of-frame) and the blob counter core; drives the core's reset, start and pixel inputs.
- Supports single-shot (key press) and continuous capture, with abort, underrun and timeout handling.

---
 rtl/blob_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_blob_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_frame_ctrl.sv
// Frame sequencer for the blob counter core: clears it, streams one frame of binarized pixels, holds the count.
// Build option BLOB_CTRL_AVG_EN: o_count reports the truncated average of the last four results.
module blob_frame_ctrl #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_cont,
  input  logic        i_abort,
  input  logic        i_sof,
  input  logic        i_pix_valid,
  input  logic        i_pix_bin,
  output logic        o_blob_rst_n,
  output logic        o_blob_start,
  output logic        o_blob_seq,
  input  logic        i_blob_valid,
  input  logic [7:0]  i_blob_count,
  output logic        o_busy,
  output logic [7:0]  o_count,
  output logic        o_count_valid,
  output logic [1:0]  o_err,
  output logic [15:0] o_frame_cnt
);
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned PIX_W = 19;
  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ARMED  = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               after_q, after_d;     // destination after CLEAR: 1 = ARMED, 0 = IDLE
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic               rst_q, rst_d;
  logic               start_q, start_d;
  logic               pix1_q, pix1_d;
  logic               vld1_q, vld1_d;
  logic               seq_q, seq_d;
  logic               busy_q, busy_d;
  logic [7:0]         count_q, count_d;
  logic               cv_q, cv_d;
  logic [1:0]         err_q, err_d;
  logic [15:0]        frame_q, frame_d;
  logic               go_clear_c, go_arm_c;
  logic [7:0]         result_c;

`ifdef BLOB_CTRL_AVG_EN
  logic [3:0][7:0]    hist_q, hist_d;
  logic [9:0]         avg_sum_c;

  assign avg_sum_c = 10'(i_blob_count) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
  assign result_c  = avg_sum_c[9:2];
`else
  assign result_c  = i_blob_count;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    after_d    = after_q;
    clr_cnt_d  = clr_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    count_d    = count_q;
    frame_d    = frame_q;
    start_d    = 1'b0;
    cv_d       = 1'b0;
    pix1_d     = 1'b0;
    vld1_d     = 1'b0;
    go_clear_c = 1'b0;
    go_arm_c   = 1'b0;
`ifdef BLOB_CTRL_AVG_EN
    hist_d     = hist_q;
`endif
    unique case (state_q)
      S_CLEAR: begin
        if (i_abort) after_d = 1'b0;
        if (clr_cnt_q == CLR_LAST) state_d = (after_q && !i_abort) ? S_ARMED : S_IDLE;
        else                       clr_cnt_d = clr_cnt_q + CLR_W'(1);
      end
      S_ARMED: begin
        if (i_abort) begin
          go_clear_c = 1'b1;
        end else if (i_sof && i_pix_valid) begin
          start_d   = 1'b1;
          pix1_d    = i_pix_bin;
          vld1_d    = 1'b1;
          pix_cnt_d = PIX_W'(1);
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_abort) begin
          go_clear_c = 1'b1;
        end else if (!i_pix_valid) begin
          err_d[0]   = 1'b1;
          go_clear_c = 1'b1;
        end else begin
          pix1_d = i_pix_bin;
          vld1_d = 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (i_abort) begin
          go_clear_c = 1'b1;
        end else if (i_blob_valid) begin
          count_d = result_c;
          cv_d    = 1'b1;
          frame_d = frame_q + 16'd1;
`ifdef BLOB_CTRL_AVG_EN
          hist_d  = {hist_q[2:0], i_blob_count};
`endif
          if (i_cont) begin
            go_clear_c = 1'b1;
            go_arm_c   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_cnt_q == TO_LAST) begin
          err_d[1]   = 1'b1;
          go_clear_c = 1'b1;
          go_arm_c   = i_cont;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: begin
        if (i_start) begin
          err_d      = 2'b00;
          go_clear_c = 1'b1;
          go_arm_c   = 1'b1;
`ifdef BLOB_CTRL_AVG_EN
          if (!i_cont) hist_d = '0;
`endif
        end
      end
    endcase
    if (go_clear_c) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
      after_d   = go_arm_c;
    end
  end

  assign rst_d  = (state_d != S_CLEAR);
  assign busy_d = (state_d != S_IDLE);
  assign seq_d  = vld1_q & pix1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      after_q    <= 1'b0;
      clr_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rst_q      <= 1'b1;
      start_q    <= 1'b0;
      pix1_q     <= 1'b0;
      vld1_q     <= 1'b0;
      seq_q      <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
      cv_q       <= 1'b0;
      err_q      <= '0;
      frame_q    <= '0;
`ifdef BLOB_CTRL_AVG_EN
      hist_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      after_q    <= after_d;
      clr_cnt_q  <= clr_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rst_q      <= rst_d;
      start_q    <= start_d;
      pix1_q     <= pix1_d;
      vld1_q     <= vld1_d;
      seq_q      <= seq_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      cv_q       <= cv_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
`ifdef BLOB_CTRL_AVG_EN
      hist_q     <= hist_d;
`endif
    end
  end

  // Core reset must drop together with the system reset, not a cycle later
  assign o_blob_rst_n  = rst_q & i_rst_n;
  assign o_blob_start  = start_q;
  assign o_blob_seq    = seq_q;
  assign o_busy        = busy_q;
  assign o_count       = count_q;
  assign o_count_valid = cv_q;
  assign o_err         = err_q;
  assign o_frame_cnt   = frame_q;
endmodule

// File: tb/tb_blob_frame_ctrl.sv
// Randomized scoreboard bench for blob_frame_ctrl (small 4x3 frame, 2-cycle clear, 16-cycle timeout).
module tb_blob_frame_ctrl;
  localparam int unsigned IMG_W      = 4;
  localparam int unsigned IMG_H      = 3;
  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned NPIX       = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_cont = 1'b0, i_abort = 1'b0, i_sof = 1'b0;
  logic        i_pix_valid = 1'b0, i_pix_bin = 1'b0, i_blob_valid = 1'b0;
  logic [7:0]  i_blob_count = 8'h00;
  logic        o_blob_rst_n, o_blob_start, o_blob_seq, o_busy, o_count_valid;
  logic [7:0]  o_count;
  logic [1:0]  o_err;
  logic [15:0] o_frame_cnt;

  blob_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_cont(i_cont), .i_abort(i_abort),
    .i_sof(i_sof), .i_pix_valid(i_pix_valid), .i_pix_bin(i_pix_bin),
    .o_blob_rst_n(o_blob_rst_n), .o_blob_start(o_blob_start), .o_blob_seq(o_blob_seq),
    .i_blob_valid(i_blob_valid), .i_blob_count(i_blob_count),
    .o_busy(o_busy), .o_count(o_count), .o_count_valid(o_count_valid),
    .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [NPIX-1:0] pix; int len; } frame_t;
  typedef struct { logic [7:0] count; logic [15:0] fcnt; } res_t;

  frame_t exp_frames[$];
  res_t   exp_res[$];
  int     checks = 0;
  int     failures = 0;

  // Reference model state
  logic [7:0]  count_m = 8'h00;
  logic [15:0] fc_m = 16'h0000;
  logic [1:0]  err_m = 2'b00;
  bit          armed_m = 1'b0;
  bit          cur_cont = 1'b0;
  int          hist_m[4] = '{0, 0, 0, 0};

  // Monitor state
  frame_t cur_f;
  int     idx_m = 0;
  bit     in_win = 1'b0;
  int     low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void model_result(input logic [7:0] r);
`ifdef BLOB_CTRL_AVG_EN
    int s;
    for (int i = 3; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = int'(r);
    s = hist_m[0] + hist_m[1] + hist_m[2] + hist_m[3];
    count_m = 8'(s / 4);
`else
    count_m = r;
`endif
    fc_m = fc_m + 16'd1;
  endfunction

  task automatic step(input bit st, input bit ab, input bit sof, input bit pv, input bit pb,
                      input bit bv, input logic [7:0] bc);
    @(posedge clk);
    #1;
    i_start = st; i_abort = ab; i_sof = sof; i_pix_valid = pv; i_pix_bin = pb;
    i_blob_valid = bv; i_blob_count = bc; i_cont = cur_cont;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blob_rst_n"}, 32'(o_blob_rst_n), 32'd0);
    check({tag, "_blob_start"}, 32'(o_blob_start), 32'd0);
    check({tag, "_blob_seq"}, 32'(o_blob_seq), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_count_valid"}, 32'(o_count_valid), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
  endtask

  // kind: 0 result, 1 underrun after k pixels, 2 timeout, 3 abort with result, 4 abort in stream, 5 reset in stream
  task automatic run_episode(input int kind, input bit cont, input logic [NPIX-1:0] pix,
                             input int k, input logic [7:0] r);
    frame_t f;
    res_t   rr;
    int     nj;
    bit     stray;
    cur_cont = cont;
    stray = 1'($urandom);
    if (!armed_m) begin
      err_m = 2'b00;
`ifdef BLOB_CTRL_AVG_EN
      if (!cont) hist_m = '{0, 0, 0, 0};
`endif
      step(1'b1, 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end else begin
      step(1'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    nj = 2 + int'($urandom_range(0, 3));
    for (int j = 0; j < nj; j++)
      step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    f.pix = pix;
    f.len = (kind == 1 || kind == 4 || kind == 5) ? k : int'(NPIX);
    exp_frames.push_back(f);
    for (int i = 0; i < f.len; i++)
      step(1'b0, 1'b0, (i == 0) || (stray && i == 5), 1'b1, pix[i], 1'b0, 8'h00);
    case (kind)
      0: begin
        nj = int'($urandom_range(0, 10));
        for (int j = 0; j < nj; j++)
          step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'h00);
        model_result(r);
        rr.count = count_m;
        rr.fcnt  = fc_m;
        exp_res.push_back(rr);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, r);
        armed_m = cont;
      end
      1: begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        err_m[0] = 1'b1;
        armed_m = 1'b0;
      end
      2: begin
        for (int j = 0; j < int'(TIMEOUT); j++)
          step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        err_m[1] = 1'b1;
        armed_m = cont;
      end
      3: begin
        nj = int'($urandom_range(0, 10));
        for (int j = 0; j < nj; j++)
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, r);
        armed_m = 1'b0;
      end
      4: begin
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom), 1'b0, 8'h00);
        armed_m = 1'b0;
      end
      default: begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_sof = 1'b0; i_pix_valid = 1'b0;
        i_pix_bin = 1'b0; i_blob_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_frames.delete();
        exp_res.delete();
        count_m = 8'h00; fc_m = 16'h0000; err_m = 2'b00; armed_m = 1'b0;
        hist_m = '{0, 0, 0, 0};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    endcase
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("ep_busy", 32'(o_busy), 32'(armed_m));
    check("ep_err", 32'(o_err), 32'(err_m));
    check("ep_count", 32'(o_count), 32'(count_m));
    check("ep_frame_cnt", 32'(o_frame_cnt), 32'(fc_m));
    check("ep_blob_rst_n", 32'(o_blob_rst_n), 32'd1);
  endtask

  // Monitor: core clear width, pixel replay after each start pulse, result pulses
  initial begin : monitor
    res_t rr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_win  = 1'b0;
        low_run = 0;
      end else begin
        if (!o_blob_rst_n) low_run++;
        else if (low_run != 0) begin
          check("clear_len", 32'(low_run), 32'(CLR_CYCLES));
          low_run = 0;
        end
        if (in_win) begin
          check("seq_pixel", 32'(o_blob_seq), 32'(cur_f.pix[idx_m]));
          idx_m++;
          if (idx_m == cur_f.len) in_win = 1'b0;
        end else begin
          check("seq_idle", 32'(o_blob_seq), 32'd0);
        end
        if (o_blob_start) begin
          checks++;
          if (exp_frames.size() == 0) begin
            failures++;
            $display("FAIL blob_start: unexpected pulse, got 1, required 0");
          end else begin
            cur_f  = exp_frames.pop_front();
            idx_m  = 0;
            in_win = 1'b1;
          end
        end
        if (o_count_valid) begin
          if (exp_res.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL count_valid: unexpected pulse with o_count=%0d, required no pulse", o_count);
          end else begin
            rr = exp_res.pop_front();
            check("count", 32'(o_count), 32'(rr.count));
            check("frame_cnt", 32'(o_frame_cnt), 32'(rr.fcnt));
          end
        end
      end
    end
  end

  initial begin : driver
    int kind;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_blob_rst_n", 32'(o_blob_rst_n), 32'd1);
    check("rel_busy", 32'(o_busy), 32'd0);

    run_episode(0, 1'b0, 12'b1111_0000_1101, 0, 8'd3);
    run_episode(0, 1'b1, NPIX'($urandom), 0, 8'd2);
    run_episode(0, 1'b1, NPIX'($urandom), 0, 8'd5);
    run_episode(0, 1'b0, NPIX'($urandom), 0, 8'd7);
    run_episode(1, 1'b0, NPIX'($urandom), 6, 8'd0);
    run_episode(2, 1'b0, NPIX'($urandom), 0, 8'd0);
    run_episode(3, 1'b0, NPIX'($urandom), 0, 8'd9);
    run_episode(4, 1'b0, NPIX'($urandom), 7, 8'd0);
    run_episode(2, 1'b1, NPIX'($urandom), 0, 8'd0);
    run_episode(0, 1'b0, NPIX'($urandom), 0, 8'($urandom));
    run_episode(5, 1'b0, NPIX'($urandom), 6, 8'd0);
    run_episode(0, 1'b0, NPIX'($urandom), 0, 8'd4);
    for (int e = 0; e < 30; e++) begin
      kind = int'($urandom_range(0, 5));
      if (kind == 5) kind = 0;
      run_episode(kind, 1'($urandom), NPIX'($urandom), int'($urandom_range(1, NPIX - 1)), 8'($urandom));
    end
    cur_cont = 1'b0;
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("end_frames_left", 32'(exp_frames.size()), 32'd0);
    check("end_results_left", 32'(exp_res.size()), 32'd0);
    check("end_window_open", 32'(in_win), 32'd0);
    check("end_busy", 32'(o_busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
